// File: rtl/csr_initiator.sv
// Single-outstanding CSR bus initiator: takes one read/write command, holds it on
// the CSR bus until wait-request drops (or a programmable timeout expires), then responds.
module csr_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [3:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [1:0]  cmd_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        csr_wr_o,
    output logic        csr_rd_o,
    output logic [3:0]  csr_addr_o,
    output logic [31:0] csr_wr_data_o,
    output logic [1:0]  csr_be_o,
    input  logic        csr_wait_rq_i,
    input  logic [31:0] csr_rd_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [15:0] tmo_cnt_q;
    logic [15:0] tmo_cnt_d;
    logic        tmo_hit;

    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        csr_wr_q;
    logic        csr_rd_q;
    logic [3:0]  csr_addr_q;
    logic [31:0] csr_wr_data_q;
    logic [1:0]  csr_be_q;

    // Counter value after the current stalled cycle; abort when it reaches the limit.
    assign tmo_cnt_d = tmo_cnt_q + 16'd1;
    assign tmo_hit   = (TMO_LIMIT != 16'd0) && (tmo_cnt_d == TMO_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= 16'd0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            csr_wr_q      <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_addr_q    <= 4'd0;
            csr_wr_data_q <= 32'd0;
            csr_be_q      <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid_i) begin
                        cmd_ready_q   <= 1'b0;
                        csr_addr_q    <= cmd_addr_i;
                        csr_wr_data_q <= cmd_wdata_i;
                        csr_be_q      <= cmd_be_i;
                        tmo_cnt_q     <= 16'd0;
                        if (cmd_addr_i[1:0] != 2'b00) begin
                            // Misaligned: answer with an error, never touch the bus.
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                            state_q     <= RESP;
                        end else begin
                            csr_wr_q <= cmd_write_i;
                            csr_rd_q <= ~cmd_write_i;
                            state_q  <= BUS;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                BUS: begin
                    if (!csr_wait_rq_i) begin
                        csr_wr_q    <= 1'b0;
                        csr_rd_q    <= 1'b0;
                        rsp_rdata_q <= csr_rd_q ? csr_rd_data_i : 32'd0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_d;
                        if (tmo_hit) begin
                            csr_wr_q    <= 1'b0;
                            csr_rd_q    <= 1'b0;
                            rsp_rdata_q <= 32'd0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign csr_wr_o      = csr_wr_q;
    assign csr_rd_o      = csr_rd_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_wr_data_o = csr_wr_data_q;
    assign csr_be_o      = csr_be_q;

endmodule

// File: tb/tb_csr_initiator.sv
// Directed bench for csr_initiator: a vector table of single transactions plus
// hand-written back-to-back, no-timeout and mid-transaction reset sequences.
module tb_csr_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = 4'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [1:0]  cmd_be = 2'd0;
    logic        rsp_ready = 1'b0;
    logic        csr_wait_rq = 1'b0;
    logic [31:0] csr_rd_data = 32'd0;

    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, csr_wr_o, csr_rd_o;
    logic [31:0] rsp_rdata_o, csr_wr_data_o;
    logic [3:0]  csr_addr_o;
    logic [1:0]  csr_be_o;

    logic        cmd_valid0 = 1'b0;
    logic        rsp_ready0 = 1'b0;
    logic        wait0 = 1'b0;
    logic        cmd_ready0, rsp_valid0, rsp_err0, csr_wr0, csr_rd0;
    logic [31:0] rsp_rdata0, csr_wr_data0;
    logic [3:0]  csr_addr0;
    logic [1:0]  csr_be0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_initiator #(.TIMEOUT_CYCLES(5)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .csr_wr_o(csr_wr_o), .csr_rd_o(csr_rd_o),
        .csr_addr_o(csr_addr_o), .csr_wr_data_o(csr_wr_data_o), .csr_be_o(csr_be_o),
        .csr_wait_rq_i(csr_wait_rq), .csr_rd_data_i(csr_rd_data)
    );

    csr_initiator #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid0), .cmd_ready_o(cmd_ready0), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready0), .rsp_rdata_o(rsp_rdata0),
        .rsp_err_o(rsp_err0), .csr_wr_o(csr_wr0), .csr_rd_o(csr_rd0),
        .csr_addr_o(csr_addr0), .csr_wr_data_o(csr_wr_data0), .csr_be_o(csr_be0),
        .csr_wait_rq_i(wait0), .csr_rd_data_i(csr_rd_data)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [1:0]  be;
        int          waits;
        logic [31:0] rd_data;
        int          exp_strobe;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   it;
        int   strobes;
        int   guard;
        logic bad;
        logic [31:0] held;
        guard = 0;
        while (!cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready_o), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_be = v.be; csr_rd_data = v.rd_data;
        csr_wait_rq = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        // Scramble the command inputs: they must not be re-sampled after acceptance.
        cmd_valid = 1'b0; cmd_addr = 4'hC; cmd_wdata = 32'hFFFF_FFFF; cmd_be = 2'b10; cmd_write = ~v.wr;
        it = 1; strobes = 0; bad = 1'b0;
        while (!rsp_valid_o && it < 2000) begin
            if (csr_wr_o || csr_rd_o) strobes++;
            if (csr_wr_o !== v.wr || csr_rd_o !== ~v.wr || csr_addr_o !== v.addr ||
                csr_wr_data_o !== v.wdata || csr_be_o !== v.be || cmd_ready_o !== 1'b0)
                bad = 1'b1;
            csr_wait_rq = (it <= v.waits);
            @(negedge clk);
            it++;
        end
        csr_wait_rq = 1'b0;
        check($sformatf("v%0d_strobe_cycles", idx), 32'(strobes), 32'(v.exp_strobe));
        check($sformatf("v%0d_rsp_latency", idx), 32'(it), 32'(v.exp_strobe + 1));
        check($sformatf("v%0d_bus_hold", idx), 32'(bad), 32'd0);
        check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err_o), 32'(v.exp_err));
        check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata_o, v.exp_rdata);
        check($sformatf("v%0d_resp_strobes", idx), 32'({csr_wr_o, csr_rd_o, cmd_ready_o}), 32'd0);
        held = rsp_rdata_o;
        @(negedge clk);
        check($sformatf("v%0d_rsp_hold", idx), 32'({rsp_valid_o, rsp_err_o}), 32'({1'b1, v.exp_err}));
        check($sformatf("v%0d_rdata_hold", idx), rsp_rdata_o, held);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_drop", idx), 32'({rsp_valid_o, cmd_ready_o}), 32'b01);
        check($sformatf("v%0d_rdata_after", idx), rsp_rdata_o, v.exp_rdata);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        int cyc;
        logic acc_pend;
        int resp_cyc[$];
        logic [31:0] resp_data[$];
        int strobe_cyc[$];

        //          wr    addr   wdata          be     W     rd_data        str err   rdata
        vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 2'b11, 0,    32'h0,         1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 4'h8, 32'h0,        2'b11, 3,    32'h12345678,  4, 1'b0, 32'h12345678};
        vecs[2] = '{1'b0, 4'h0, 32'h0,        2'b11, 1000, 32'h55AA55AA,  5, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 4'h6, 32'hCAFEF00D, 2'b11, 0,    32'h0,         0, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 4'h0, 32'h0,        2'b01, 1,    32'hAABBCCDD,  2, 1'b0, 32'hAABBCCDD};
        vecs[5] = '{1'b1, 4'h8, 32'h0BADF00D, 2'b01, 2,    32'hFFFFFFFF,  3, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 4'h4, 32'h0,        2'b10, 4,    32'h87654321,  5, 1'b0, 32'h87654321};
        vecs[7] = '{1'b0, 4'h4, 32'h0,        2'b11, 5,    32'h11112222,  5, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 4'h1, 32'h0,        2'b11, 0,    32'h0,         0, 1'b1, 32'h0};

        // Asynchronous reset: outputs clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("reset_outputs", 32'({cmd_ready_o, rsp_valid_o, rsp_err_o, csr_wr_o, csr_rd_o, csr_addr_o, csr_be_o}), 32'd0);
        check("reset_data", rsp_rdata_o | csr_wr_data_o, 32'd0);
        repeat (2) @(negedge clk);
        check("reset_cmd_ready_held", 32'(cmd_ready_o), 32'd0);
        reset = 1'b1;
        #1;
        check("release_cmd_ready_pre", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        check("release_cmd_ready_post", 32'(cmd_ready_o), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
            $display("vec %0d wr=%0b addr=%h waits=%0d err=%0b rdata=%h", i, vecs[i].wr, vecs[i].addr,
                     vecs[i].waits, rsp_err_o, rsp_rdata_o);
        end

        // Back-to-back reads with valid/ready held; responder returns wdata^0x5A5A0000.
        k = 0; cyc = 0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4; cmd_wdata = 32'h100; cmd_be = 2'b11;
        rsp_ready = 1'b1; csr_wait_rq = 1'b0;
        acc_pend = cmd_ready_o;
        while (cyc < 20) begin
            csr_rd_data = csr_wr_data_o ^ 32'h5A5A_0000;
            @(negedge clk);
            cyc++;
            csr_rd_data = csr_wr_data_o ^ 32'h5A5A_0000;
            if (rsp_valid_o) begin
                resp_cyc.push_back(cyc);
                resp_data.push_back(rsp_rdata_o);
            end
            if (csr_wr_o || csr_rd_o) strobe_cyc.push_back(cyc);
            if (acc_pend) begin
                k++;
                if (k < 4) begin
                    cmd_addr = 4'(4 * ((k + 1) % 3));
                    cmd_wdata = 32'h100 + 32'(k);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            acc_pend = cmd_ready_o && cmd_valid;
        end
        rsp_ready = 1'b0;
        check("b2b_resp_count", 32'(resp_cyc.size()), 32'd4);
        check("b2b_strobe_count", 32'(strobe_cyc.size()), 32'd4);
        for (int i = 0; i < resp_data.size() && i < 4; i++) begin
            check($sformatf("b2b_rdata%0d", i), resp_data[i], (32'h100 + 32'(i)) ^ 32'h5A5A_0000);
            $display("b2b rsp %0d cycle=%0d rdata=%h", i, resp_cyc[i], resp_data[i]);
            if (i > 0) begin
                check($sformatf("b2b_rsp_gap%0d", i), 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd3);
            end
        end
        for (int i = 1; i < strobe_cyc.size() && i < 4; i++)
            check($sformatf("b2b_strobe_gap%0d", i), 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd3);

        // TIMEOUT_CYCLES=0 instance: stalled read never aborts.
        @(negedge clk);
        cmd_valid0 = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8; cmd_wdata = 32'h0; wait0 = 1'b1;
        csr_rd_data = 32'h0BEEF0D0;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        repeat (1000) @(negedge clk);
        check("notmo_still_strobing", 32'({csr_rd0, rsp_valid0}), 32'b10);
        wait0 = 1'b0;
        @(negedge clk);
        check("notmo_complete", 32'({rsp_valid0, rsp_err0, csr_rd0}), 32'b100);
        check("notmo_rdata", rsp_rdata0, 32'h0BEEF0D0);
        $display("notmo rsp valid=%0b err=%0b rdata=%h", rsp_valid0, rsp_err0, rsp_rdata0);
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;

        // Reset while stalled in BUS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4; cmd_wdata = 32'h77; csr_wait_rq = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rst_bus_precond", 32'(csr_rd_o), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_bus_outputs", 32'({cmd_ready_o, rsp_valid_o, rsp_err_o, csr_wr_o, csr_rd_o, csr_addr_o, csr_be_o}), 32'd0);
        check("rst_bus_data", rsp_rdata_o | csr_wr_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        repeat (4) @(negedge clk);
        check("rst_no_response", 32'({rsp_valid_o, csr_rd_o, csr_wr_o}), 32'd0);
        csr_wait_rq = 1'b0;
        $display("reset-in-bus rsp_valid=%0b cmd_ready=%0b", rsp_valid_o, cmd_ready_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_initiator.md
# csr_initiator

Bus initiator for the DMA control/status register port. Accepts single read/write commands from a host-side requester, drives them onto the CSR bus (strobes, address, write data, byte enables) and holds them until the DMA CSR responder drops wait-request. It then returns read data or write completion on a response handshake. A programmable timeout aborts transactions that the responder never completes.

## Interface
- TIMEOUT_CYCLES, default 64: consecutive wait-request cycles before abort; 0 disables the timeout; legal range 0..65535.
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low (asserted when 0); deassertion is synchronous to clk by the system
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  initiator can accept a command
- cmd_write_i  input  1  1 = write, 0 = read
- cmd_addr_i  input  4  CSR byte address (0x0, 0x4, 0x8 are mapped)
- cmd_wdata_i  input  32  write data
- cmd_be_i  input  2  byte enables; bit0 covers data[15:0], bit1 covers data[31:16]
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  requester accepts response
- rsp_rdata_o  output  32  read data; 0 for writes and errors
- rsp_err_o  output  1  1 = misaligned address or timeout
- csr_wr_o  output  1  write strobe to responder
- csr_rd_o  output  1  read strobe to responder
- csr_addr_o  output  4  address to responder
- csr_wr_data_o  output  32  write data to responder
- csr_be_o  output  2  byte enables to responder
- csr_wait_rq_i  input  1  responder stall; transfer completes on a cycle it is 0
- csr_rd_data_i  input  32  responder read data; valid on the completing read cycle

## Operation
- FSM with 3 states: IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE**
  - cmd_ready_o=1.
  - On cmd_valid_i: latch write, addr, wdata and be.
  - If cmd_addr_i[1:0]!=0, go to RESP with rsp_err_o=1 and rdata 0. No bus strobe is ever driven.
  - Otherwise go to BUS. Assert csr_wr_o (write) or csr_rd_o (read) and drive the latched address, data and be. The timeout counter clears to 0.
- **BUS**
  - Strobe, address, data and be are held stable every cycle.
  - Exactly one of csr_wr_o/csr_rd_o is high.
  - cmd_ready_o=0.
  - A sampled csr_wait_rq_i=0 completes the transfer:
    - deassert the strobe;
    - for reads, latch csr_rd_data_i into rsp_rdata_o; for writes, set rsp_rdata_o to 0;
    - rsp_err_o=0; go to RESP.
  - A sampled csr_wait_rq_i=1 increments the 16-bit timeout counter.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, abort:
    - deassert the strobe;
    - rsp_rdata_o=0, rsp_err_o=1; go to RESP.
  - A completion on the same edge as the threshold sample is impossible, because completion requires wait=0.
- **RESP**
  - rsp_valid_o=1 with rdata/err stable; cmd_ready_o=0; strobes 0.
  - On rsp_ready_i: go to IDLE and clear rsp_valid_o. rsp_rdata_o and rsp_err_o hold their values until the next response.
- All outputs are registered.
- Reset values (immediately on reset=0, asynchronously):
  - cmd_ready_o=0 while in reset, 1 after the first clock in IDLE;
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0;
  - csr_wr_o=0, csr_rd_o=0, csr_addr_o=0, csr_wr_data_o=0, csr_be_o=0.
- Reset mid-transaction abandons it: no response is generated and strobes drop immediately.
- cmd_* changing while not accepted has no effect. Address, data and be are never re-sampled after acceptance.

## Timing
- Command accepted at edge E:
  - strobe visible from E until the completion edge E+1+W, where W = number of cycles wait-request was sampled 1;
  - rsp_valid_o visible from E+1+W.
- Minimum occupancy is 3 cycles per transaction (IDLE, BUS, RESP) with rsp_ready_i held at 1. Strobes are therefore low for at least 2 cycles between transactions, which gives the responder's FSM time to return to idle.
- Misaligned command: rsp_valid_o visible from E; 2 cycles minimum.
- Timeout: strobe high for exactly TIMEOUT_CYCLES cycles; rsp_valid_o visible from E+TIMEOUT_CYCLES.
- rsp_ready_i may be high before rsp_valid_o. The response is consumed on the first cycle both are 1.

## Test plan
- Write 0xDEADBEEF to addr 0x4, be=2'b11, wait_rq low:
  - csr_wr_o high for exactly 1 cycle with addr 0x4 and data 0xDEADBEEF;
  - rsp_valid_o the next cycle with err=0 and rdata=0.
- Read addr 0x8, wait_rq high for 3 cycles, then low with rd_data=0x12345678:
  - csr_rd_o high for 4 cycles with address stable;
  - rsp_rdata_o=0x12345678, err=0.
- TIMEOUT_CYCLES=5, read with wait_rq stuck high:
  - csr_rd_o high for 5 cycles then low;
  - rsp_err_o=1, rsp_rdata_o=0. Repeat with TIMEOUT_CYCLES=0: no abort after 1000 cycles.
- Command to addr 0x6:
  - no strobe ever asserted; rsp_valid_o the next cycle with err=1.
- Back-to-back: 4 commands with cmd_valid_i and rsp_ready_i held at 1, zero wait:
  - one response every 3 cycles, in order;
  - strobes low for 2 cycles between transfers.
- Assert reset while in BUS with wait_rq high:
  - all outputs zero without a clock edge; no response after release;
  - cmd_ready_o=1 one cycle after release.
